// File: rtl/bcd_random_gen_if.sv
// Control and capture bundle between the game controller and the BCD secret-number source.
// Latency: none, wires only.
// Backpressure: none; req is level-sampled by the generator only while it is idle.
interface bcd_random_gen_if #(
  parameter int DIGITS = 4
);
  logic                  run;
  logic                  clr;
  logic                  req;
  logic                  busy;
  logic                  valid;
  logic [4*DIGITS-1:0]   out;

  // Controller side drives the requests and consumes the captured value.
  modport master (
    output run,
    output clr,
    output req,
    input  busy,
    input  valid,
    input  out
  );

  // Generator side.
  modport slave (
    input  run,
    input  clr,
    input  req,
    output busy,
    output valid,
    output out
  );
endinterface

// File: rtl/bcd_random_gen.sv
// Free-running BCD counter with a search FSM that captures the first value meeting the game rules.
// Latency: 2 edges minimum from req sampled to valid; one extra edge per rejected counter value.
// Backpressure: req is ignored while busy; valid holds the value until the next req is sampled.
module bcd_random_gen #(
  parameter int DIGITS       = 4,
  parameter int UNIQUE       = 0,
  parameter int LEAD_ZERO_OK = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_random_gen_if.slave    bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   cnt;
  logic [W-1:0]   cnt_inc;
  logic [W-1:0]   out_q;
  logic           valid_q;
  logic           carry;
  logic           distinct;
  logic           lead_ok;
  logic           ok;
  logic           inc;
  logic           capture;
  logic           arm;

  // Ripple BCD increment: a 9 rolls to 0 and carries upward, all-nines wraps to zero.
  always_comb begin
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Accept predicate evaluated on the registered counter value.
  always_comb begin
    distinct = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      for (int j = 0; j < DIGITS; j++) begin
        if (j > i && cnt[4*i +: 4] == cnt[4*j +: 4]) begin
          distinct = 1'b0;
        end
      end
    end
    lead_ok = (cnt[W-1 -: 4] != 4'd0);
    ok      = ((UNIQUE == 0) || distinct) && ((LEAD_ZERO_OK != 0) || lead_ok);
  end

  // Next state and datapath controls; entering SEARCH also advances the counter.
  always_comb begin
    state_nxt = state;
    inc       = bus.run;
    capture   = 1'b0;
    arm       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          state_nxt = SEARCH;
          inc       = 1'b1;
          arm       = 1'b1;
        end
      end
      SEARCH: begin
        inc = 1'b1;
        if (ok) begin
          state_nxt = IDLE;
          capture   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter: clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bus.clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt_inc;
    end
  end

  // Capture register: load on accept, drop valid when a new search is armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (capture) begin
      out_q   <= cnt;
      valid_q <= 1'b1;
    end else if (arm) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.busy  = (state == SEARCH);
  assign bus.valid = valid_q;
  assign bus.out   = out_q;
endmodule

// File: tb/tb_bcd_random_gen.sv
// Scoreboard bench for bcd_random_gen: three instances cover default, unique, and unique with no leading zero.
// Expected captures are queued at request time and popped by a monitor on each valid rising edge.
// Directed checks cover counting, wrap, clear priority, busy duration and asynchronous reset.
module tb_bcd_random_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_random_gen_if #(.DIGITS(4)) if0 ();
  bcd_random_gen_if #(.DIGITS(4)) if1 ();
  bcd_random_gen_if #(.DIGITS(4)) if2 ();

  bcd_random_gen #(.DIGITS(4), .UNIQUE(0), .LEAD_ZERO_OK(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  bcd_random_gen #(.DIGITS(4), .UNIQUE(1), .LEAD_ZERO_OK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  bcd_random_gen #(.DIGITS(4), .UNIQUE(1), .LEAD_ZERO_OK(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [15:0] out_a [3];
  logic [2:0]  vld_now;
  logic [2:0]  prev_vld = '0;

  assign out_a[0] = if0.out;
  assign out_a[1] = if1.out;
  assign out_a[2] = if2.out;
  assign vld_now  = {if2.valid, if1.valid, if0.valid};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_accept(input int id, input logic [15:0] got);
    exp_t e;
    logic have;
    have = 1'b0;
    e.val = '0;
    e.at  = 0;
    case (id)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    n_checks++;
    if (!have) begin
      n_fail++;
      $display("FAIL accept%0d: unexpected capture out=%h at edge %0d, expected none", id, got, cyc);
    end else if (got !== e.val || cyc != e.at) begin
      n_fail++;
      $display("FAIL accept%0d: out=%h at edge %0d, expected %h at edge %0d", id, got, cyc, e.val, e.at);
    end
  endtask

  // Monitor: every rising valid must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld_now[i] && !prev_vld[i]) check_accept(i, out_a[i]);
    end
    prev_vld = vld_now;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int busy_cycles;
    exp_t e;

    rst_n = 1'b0;
    if0.run = 1'b0; if0.clr = 1'b0; if0.req = 1'b0;
    if1.run = 1'b0; if1.clr = 1'b0; if1.req = 1'b0;
    if2.run = 1'b0; if2.clr = 1'b0; if2.req = 1'b0;
    #12;
    chk("reset_busy0", {31'd0, if0.busy}, 32'd0);
    chk("reset_valid0", {31'd0, if0.valid}, 32'd0);
    chk("reset_out0", {16'd0, if0.out}, 32'd0);
    chk("reset_cnt0", {16'd0, u_dut0.cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Counting from reset: twelve run edges.
    if0.run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("count_valid", {31'd0, if0.valid}, 32'd0);
      chk("count_out", {16'd0, if0.out}, 32'd0);
    end
    chk("count_12", {16'd0, u_dut0.cnt}, 32'h0012);

    // Clear has priority over run.
    if0.clr = 1'b1;
    step();
    chk("clr_with_run", {16'd0, u_dut0.cnt}, 32'h0000);
    if0.clr = 1'b0;
    step(42);
    chk("count_42", {16'd0, u_dut0.cnt}, 32'h0042);

    // Default capture: minimum latency.
    if0.req = 1'b1;
    e.val = 16'h0043; e.at = cyc + 2; q0.push_back(e);
    step();
    if0.req = 1'b0;
    chk("cap_busy_k", {31'd0, if0.busy}, 32'd1);
    chk("cap_valid_k", {31'd0, if0.valid}, 32'd0);
    step();
    chk("cap_busy_k1", {31'd0, if0.busy}, 32'd0);
    chk("cap_valid_k1", {31'd0, if0.valid}, 32'd1);
    chk("cap_cnt_k1", {16'd0, u_dut0.cnt}, 32'h0044);

    // Wrap: all-nines to all-zeros while valid/out hold.
    if0.clr = 1'b1;
    step();
    if0.clr = 1'b0;
    step(9999);
    chk("cnt_9999", {16'd0, u_dut0.cnt}, 32'h9999);
    step();
    chk("cnt_wrap", {16'd0, u_dut0.cnt}, 32'h0000);
    if0.run = 1'b0;
    chk("hold_valid0", {31'd0, if0.valid}, 32'd1);
    chk("hold_out0", {16'd0, if0.out}, 32'h0043);

    // Unique digits: 124 evaluations; a second req mid-search is ignored.
    if1.clr = 1'b1;
    if1.req = 1'b1;
    e.val = 16'h0123; e.at = cyc + 1 + 124; q1.push_back(e);
    step();
    if1.clr = 1'b0;
    if1.req = 1'b0;
    chk("uniq_busy", {31'd0, if1.busy}, 32'd1);
    step(4);
    if1.req = 1'b1;
    step();
    if1.req = 1'b0;
    t = 0;
    while (!if1.valid && t < 300) begin
      step();
      t++;
    end
    chk("uniq_done", {31'd0, if1.valid}, 32'd1);
    chk("uniq_cnt", {16'd0, u_dut1.cnt}, 32'h0124);
    chk("uniq_busy_low", {31'd0, if1.busy}, 32'd0);
    step(5);
    chk("uniq_stay_valid", {31'd0, if1.valid}, 32'd1);

    // New req while valid: valid drops, out holds until the next accept.
    if1.req = 1'b1;
    e.val = 16'h0125; e.at = cyc + 2; q1.push_back(e);
    step();
    if1.req = 1'b0;
    chk("rereq_valid", {31'd0, if1.valid}, 32'd0);
    chk("rereq_out_hold", {16'd0, if1.out}, 32'h0123);
    chk("rereq_busy", {31'd0, if1.busy}, 32'd1);
    step();
    chk("rereq_valid2", {31'd0, if1.valid}, 32'd1);
    chk("rereq_cnt", {16'd0, u_dut1.cnt}, 32'h0126);

    // Unique, no leading zero: 1024 evaluations, busy for exactly 1024 cycles.
    if2.clr = 1'b1;
    if2.req = 1'b1;
    e.val = 16'h1023; e.at = cyc + 1 + 1024; q2.push_back(e);
    step();
    if2.clr = 1'b0;
    if2.req = 1'b0;
    busy_cycles = 0;
    t = 0;
    while (if2.busy && t < 2000) begin
      busy_cycles++;
      step();
      t++;
    end
    chk("nolz_busy_cycles", busy_cycles, 32'd1024);
    chk("nolz_valid", {31'd0, if2.valid}, 32'd1);

    // Reset mid-search: outputs clear without a clock edge.
    if2.clr = 1'b1;
    if2.req = 1'b1;
    step();
    if2.clr = 1'b0;
    if2.req = 1'b0;
    step(100);
    chk("mid_busy", {31'd0, if2.busy}, 32'd1);
    chk("mid_out_hold", {16'd0, if2.out}, 32'h1023);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, if2.busy}, 32'd0);
    chk("arst_valid", {31'd0, if2.valid}, 32'd0);
    chk("arst_out", {16'd0, if2.out}, 32'd0);
    chk("arst_out1", {16'd0, if1.out}, 32'd0);
    step();
    rst_n = 1'b1;
    step(5);
    chk("post_rst_busy", {31'd0, if2.busy}, 32'd0);
    chk("queues_empty", q0.size() + q1.size() + q2.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
